// File: rtl/code_conv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : code_conv_pkg
//  Description : Shared types, constants and helpers for the code-converter set.
//  Revision    : 1.0  initial release
// ============================================================================
package code_conv_pkg;

    localparam int          BCD_W   = 4;
    localparam logic [3:0]  BCD_MAX = 4'd9;
    localparam int          MUL_W   = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } conv_state_t;

    // Shift-and-add times ten; callers zero-extend in and truncate out.
    function automatic logic [MUL_W-1:0] mul10(input logic [MUL_W-1:0] acc);
        return (acc << 3) + (acc << 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_mac.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit_mac
//  Description : Combinational acc*10 + digit step; digit>9 flag present only
//                when BCD2BIN_DIGIT_CHECK_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_digit_mac
    import code_conv_pkg::*;
#(
    parameter int BIN_W = 10
) (
    input  logic [BIN_W-1:0] acc_in,
    input  logic [BCD_W-1:0] digit,
`ifdef BCD2BIN_DIGIT_CHECK_EN
    output logic             dig_bad,
`endif
    output logic [BIN_W-1:0] acc_out
);

    localparam int c_WIDE_W = BIN_W + 4;

    logic [c_WIDE_W-1:0] w_wide;

    assign w_wide  = c_WIDE_W'(mul10(MUL_W'(acc_in))) + c_WIDE_W'(digit);
    assign acc_out = BIN_W'(w_wide);

`ifdef BCD2BIN_DIGIT_CHECK_EN
    assign dig_bad = (digit > BCD_MAX);
`endif

endmodule
`default_nettype wire

// File: rtl/bcd2bin_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bcd2bin_seq
//  Description : Sequential BCD-to-binary converter, one digit per clock, MSD
//                first. Optional digit validation via BCD2BIN_DIGIT_CHECK_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module bcd2bin_seq
    import code_conv_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BCD_W*DIGITS-1:0] bcd_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BIN_W-1:0]        bin_out,
    output logic                    out_err
);

    localparam int              c_CNT_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DIGITS - 1);

    generate
        if ((DIGITS < 1) || ((64'd10 ** DIGITS) - 64'd1 >= (64'd1 << BIN_W))) begin : g_width_check
            $error("bcd2bin_seq: BIN_W too small for DIGITS");
        end
    endgenerate

    conv_state_t               r_state;
    conv_state_t               w_state_next;
    logic [BCD_W*DIGITS-1:0]   r_word;
    logic [BIN_W-1:0]          r_acc;
    logic [c_CNT_W-1:0]        r_cnt;
    logic [BIN_W-1:0]          w_acc_next;
    logic [BCD_W-1:0]          w_digit;

    // The latched word shifts left each step so the current digit is always on top.
    assign w_digit = r_word[BCD_W*DIGITS-1 -: BCD_W];

`ifdef BCD2BIN_DIGIT_CHECK_EN
    logic r_err;
    logic w_dig_bad;

    bcd_digit_mac #(.BIN_W(BIN_W)) u_mac (
        .acc_in  (r_acc),
        .digit   (w_digit),
        .dig_bad (w_dig_bad),
        .acc_out (w_acc_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (r_state == IDLE && in_valid) begin
            r_err <= 1'b0;
        end else if (r_state == CONV) begin
            r_err <= r_err | w_dig_bad;
        end
    end

    assign bin_out = r_err ? '0 : r_acc;
    assign out_err = r_err && (r_state == DONE);
`else
    bcd_digit_mac #(.BIN_W(BIN_W)) u_mac (
        .acc_in  (r_acc),
        .digit   (w_digit),
        .acc_out (w_acc_next)
    );

    assign bin_out = r_acc;
    assign out_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)            w_state_next = CONV;
            CONV:    if (r_cnt == c_CNT_LAST) w_state_next = DONE;
            DONE:    if (out_ready)           w_state_next = IDLE;
            default:                          w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_word <= '0;
            r_acc  <= '0;
            r_cnt  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_word <= bcd_in;
                        r_acc  <= '0;
                        r_cnt  <= '0;
                    end
                end
                CONV: begin
                    r_acc  <= w_acc_next;
                    r_word <= r_word << BCD_W;
                    r_cnt  <= r_cnt + c_CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_bcd2bin_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd2bin_seq
//  Description : Self-checking bench for bcd2bin_seq (DIGITS=3, BIN_W=10).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bcd2bin_seq;

    localparam int DIGITS = 3;
    localparam int BIN_W  = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [11:0]       bcd_in;
    logic              out_valid;
    logic              out_ready;
    logic [BIN_W-1:0]  bin_out;
    logic              out_err;

    int n_checks = 0;
    int n_errors = 0;

    bcd2bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bcd_in    (bcd_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bin_out   (bin_out),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0]      bcd;
        int               stall;
        logic [BIN_W-1:0] exp_bin;
        logic             exp_err;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sends one word, checks latency, in_ready during the busy period, hold under stall and release.
    task automatic run_word(input vec_t v);
        int lat;
        logic [BIN_W-1:0] held;
        check("idle_in_ready", int'(in_ready), 1);
        in_valid  = 1'b1;
        bcd_in    = v.bcd;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        bcd_in   = 12'hFFF;
        lat = 0;
        while (!out_valid && lat < 20) begin
            check("busy_in_ready", int'(in_ready), 0);
            step();
            lat++;
        end
        check("latency", lat, DIGITS);
        held = bin_out;
        for (int i = 0; i < v.stall; i++) begin
            step();
            check("stall_out_valid", int'(out_valid), 1);
            check("stall_bin_stable", int'(bin_out), int'(held));
            check("stall_in_ready", int'(in_ready), 0);
        end
        check("bin_out", int'(bin_out), int'(v.exp_bin));
        check("out_err", int'(out_err), int'(v.exp_err));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("release_out_valid", int'(out_valid), 0);
        check("release_in_ready", int'(in_ready), 1);
    endtask

    vec_t vecs[7];

    initial begin
        logic [3:0]       d2, d1, d0;
        logic [BIN_W-1:0] exp_q[$];
        int               sent, recv, cyc;
        logic [BIN_W-1:0] exp_v;

        vecs[0] = '{bcd: 12'h255, stall: 0,  exp_bin: 10'd255, exp_err: 1'b0};
        vecs[1] = '{bcd: 12'h000, stall: 0,  exp_bin: 10'd0,   exp_err: 1'b0};
        vecs[2] = '{bcd: 12'h999, stall: 0,  exp_bin: 10'd999, exp_err: 1'b0};
        vecs[3] = '{bcd: 12'h128, stall: 10, exp_bin: 10'd128, exp_err: 1'b0};
        vecs[4] = '{bcd: 12'h100, stall: 2,  exp_bin: 10'd100, exp_err: 1'b0};
        vecs[5] = '{bcd: 12'h001, stall: 0,  exp_bin: 10'd1,   exp_err: 1'b0};
`ifdef BCD2BIN_DIGIT_CHECK_EN
        vecs[6] = '{bcd: 12'h1A3, stall: 1,  exp_bin: 10'd0,   exp_err: 1'b1};
`else
        vecs[6] = '{bcd: 12'h1A3, stall: 1,  exp_bin: 10'd203, exp_err: 1'b0};
`endif

        rst = 1'b1; in_valid = 1'b0; bcd_in = 12'h0; out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_bin_out", int'(bin_out), 0);
        check("rst_out_err", int'(out_err), 0);

        for (int i = 0; i < 7; i++) run_word(vecs[i]);

        // Reset in the middle of a conversion abandons the word.
        in_valid = 1'b1;
        bcd_in   = 12'h777;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_in_ready", int'(in_ready), 1);
        check("midrst_bin_out", int'(bin_out), 0);
        run_word('{bcd: 12'h042, stall: 0, exp_bin: 10'd42, exp_err: 1'b0});

        // Streaming: in_valid held high, random backpressure, scoreboard queue.
        sent = 0; recv = 0; cyc = 0;
        d2 = 4'($urandom_range(0, 9)); d1 = 4'($urandom_range(0, 9)); d0 = 4'($urandom_range(0, 9));
        bcd_in   = {d2, d1, d0};
        in_valid = 1'b1;
        while (recv < 1000 && cyc < 20000) begin
            out_ready = 1'($urandom_range(0, 1));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("stream_unexpected", 1, 0);
                end else begin
                    exp_v = exp_q.pop_front();
                    check("stream_bin_out", int'(bin_out), int'(exp_v));
                end
                recv++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(10'(d2 * 100 + d1 * 10 + d0));
                sent++;
            end
            step();
            cyc++;
            if (in_ready && sent < 1000) begin
                d2 = 4'($urandom_range(0, 9)); d1 = 4'($urandom_range(0, 9)); d0 = 4'($urandom_range(0, 9));
                bcd_in = {d2, d1, d0};
            end
            if (sent >= 1000) in_valid = 1'b0;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("stream_recv_count", recv, 1000);
        check("stream_sent_count", sent, 1000);
        check("stream_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
